// File: rtl/sim_test_monitor_pkg.sv
// Shared definitions for the simulation/self-test monitor: status encoding and
// default mailbox addresses used by the RTL, benches and debug display.
package sim_test_pkg;

  typedef enum logic [2:0] {
    RUN     = 3'd0,
    PASS    = 3'd1,
    FAIL    = 3'd2,
    TIMEOUT = 3'd3,
    HANG    = 3'd4
  } test_status_t;

  localparam logic [31:0] DEFAULT_TOHOST_ADDR  = 32'h0000_FF00;
  localparam logic [31:0] DEFAULT_CONSOLE_ADDR = 32'h0000_FF04;

endpackage

// File: rtl/sim_test_monitor_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers and a registered head word, so the
// consumer sees head/valid straight from flops.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             valid,
  output logic             full
);

  localparam int unsigned AW = $clog2(DEPTH);

  if (DEPTH < 2 || (1 << AW) != DEPTH) begin : g_bad_depth
    $error("sync_fifo DEPTH must be a power of two and at least 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      rd_ptr;
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_next;
  logic [AW:0]      wr_next;
  logic             do_push;
  logic             do_pop;

  // Handshake qualification and next pointers; a pop frees room for a same-cycle push.
  always_comb begin
    full    = (rd_ptr[AW-1:0] == wr_ptr[AW-1:0]) && (rd_ptr[AW] != wr_ptr[AW]);
    do_pop  = pop && valid;
    do_push = push && (!full || do_pop);
    rd_next = rd_ptr + {{AW{1'b0}}, do_pop};
    wr_next = wr_ptr + {{AW{1'b0}}, do_push};
  end

  // Pointer, valid and head registers; head bypasses the array when the new head is being written.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      valid  <= 1'b0;
      head   <= '0;
    end else begin
      rd_ptr <= rd_next;
      wr_ptr <= wr_next;
      valid  <= (rd_next != wr_next);
      if (do_push && (wr_ptr[AW-1:0] == rd_next[AW-1:0])) begin
        head <= push_data;
      end else begin
        head <= mem[rd_next[AW-1:0]];
      end
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/sim_test_monitor.sv
// Passive end-of-test monitor on the core's memory buses: tohost pass/fail,
// cycle timeout, PC-stall hang detection and a buffered console byte stream.
module sim_test_monitor
  import sim_test_pkg::*;
#(
  parameter logic [31:0] TOHOST_ADDR  = DEFAULT_TOHOST_ADDR,
  parameter logic [31:0] CONSOLE_ADDR = DEFAULT_CONSOLE_ADDR,
  parameter int unsigned MAX_CYCLES   = 1000,
  parameter int unsigned STALL_LIMIT  = 16,
  parameter int unsigned CYCLE_WIDTH  = 32,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic [31:0]            imem_addr_in,
  input  logic [31:0]            dmem_addr_in,
  input  logic [31:0]            dmem_data_in,
  input  logic [3:0]             dmem_write_enable_in,
  output logic                   done_out,
  output logic                   pass_out,
  output logic [2:0]             status_out,
  output logic [30:0]            fail_code_out,
  output logic [CYCLE_WIDTH-1:0] cycle_count_out,
  output logic [7:0]             char_data_out,
  output logic                   char_valid_out,
  input  logic                   char_ready_in,
  output logic                   overflow_out
);

  if (TOHOST_ADDR[31:2] == CONSOLE_ADDR[31:2]) begin : g_addr_clash
    $error("TOHOST_ADDR and CONSOLE_ADDR must be distinct words");
  end

  test_status_t state;
  test_status_t state_next;
  logic [30:0]  fail_next;
  logic [31:0]  prev_imem;
  logic         prev_valid;
  logic [31:0]  stall_count;
  logic [31:0]  stall_next;
  logic         same_pc;
  logic         tohost_hit;
  logic         timeout_hit;
  logic         hang_hit;
  logic         con_push;
  logic         con_pop;
  logic         fifo_full;
  logic         addr_lsb_unused;

  assign addr_lsb_unused = ^dmem_addr_in[1:0];

  // Trigger detection and terminal-state selection; tohost beats timeout beats hang.
  always_comb begin
    tohost_hit  = (dmem_addr_in[31:2] == TOHOST_ADDR[31:2]) && (dmem_write_enable_in == 4'b1111);
    same_pc     = prev_valid && (imem_addr_in == prev_imem);
    if (same_pc) begin
      stall_next = (stall_count != 32'hFFFF_FFFF) ? stall_count + 32'd1 : stall_count;
    end else begin
      stall_next = 32'd0;
    end
    timeout_hit = (MAX_CYCLES != 0) && (cycle_count_out == CYCLE_WIDTH'(MAX_CYCLES - 1));
    hang_hit    = (STALL_LIMIT != 0) && same_pc && (stall_next >= STALL_LIMIT - 1);
    con_push    = (state == RUN) && (dmem_addr_in[31:2] == CONSOLE_ADDR[31:2]) &&
                  dmem_write_enable_in[0];
    con_pop     = char_valid_out && char_ready_in;
    state_next  = state;
    fail_next   = fail_code_out;
    case (state)
      RUN: begin
        if (tohost_hit && (dmem_data_in == 32'd1)) begin
          state_next = PASS;
        end else if (tohost_hit && dmem_data_in[0]) begin
          state_next = FAIL;
          fail_next  = dmem_data_in[31:1];
        end else if (timeout_hit) begin
          state_next = TIMEOUT;
        end else if (hang_hit) begin
          state_next = HANG;
        end else begin
          state_next = RUN;
        end
      end
      default: state_next = state;
    endcase
  end

  // State, status outputs, cycle/stall counters and overflow flag.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state           <= RUN;
      done_out        <= 1'b0;
      pass_out        <= 1'b0;
      status_out      <= RUN;
      fail_code_out   <= 31'd0;
      cycle_count_out <= '0;
      stall_count     <= 32'd0;
      prev_imem       <= 32'd0;
      prev_valid      <= 1'b0;
      overflow_out    <= 1'b0;
    end else begin
      state         <= state_next;
      done_out      <= (state_next != RUN);
      pass_out      <= (state_next == PASS);
      status_out    <= state_next;
      fail_code_out <= fail_next;
      if ((state == RUN) && (cycle_count_out != {CYCLE_WIDTH{1'b1}})) begin
        cycle_count_out <= cycle_count_out + {{(CYCLE_WIDTH-1){1'b0}}, 1'b1};
      end
      stall_count <= stall_next;
      prev_imem   <= imem_addr_in;
      prev_valid  <= 1'b1;
      if (con_push && fifo_full && !con_pop) begin
        overflow_out <= 1'b1;
      end
    end
  end

  sync_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_console_fifo (
    .clk      (clk_in),
    .rst      (rst_in),
    .push     (con_push),
    .push_data(dmem_data_in[7:0]),
    .pop      (con_pop),
    .head     (char_data_out),
    .valid    (char_valid_out),
    .full     (fifo_full)
  );

endmodule

// File: tb/tb_sim_test_monitor.sv
// Directed self-checking bench for sim_test_monitor; console bytes are tracked
// through a scoreboard queue filled on store and drained on handshake.
module tb_sim_test_monitor;
  import sim_test_pkg::*;

  localparam logic [31:0] TOHOST  = 32'h0000_FF00;
  localparam logic [31:0] CONSOLE = 32'h0000_FF04;

  logic        clk;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_data;
  logic [3:0]  dmem_we;
  logic        done;
  logic        pass;
  logic [2:0]  status;
  logic [30:0] fail_code;
  logic [31:0] cycle_count;
  logic [7:0]  char_data;
  logic        char_valid;
  logic        char_ready;
  logic        overflow;

  int          n_cmp = 0;
  int          n_err = 0;
  logic        hold;
  logic [7:0]  sb[$];
  logic [7:0]  exp_byte;

  sim_test_monitor #(
    .TOHOST_ADDR (TOHOST),
    .CONSOLE_ADDR(CONSOLE),
    .MAX_CYCLES  (80),
    .STALL_LIMIT (16),
    .CYCLE_WIDTH (32),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk_in              (clk),
    .rst_in              (rst),
    .imem_addr_in        (imem_addr),
    .dmem_addr_in        (dmem_addr),
    .dmem_data_in        (dmem_data),
    .dmem_write_enable_in(dmem_we),
    .done_out            (done),
    .pass_out            (pass),
    .status_out          (status),
    .fail_code_out       (fail_code),
    .cycle_count_out     (cycle_count),
    .char_data_out       (char_data),
    .char_valid_out      (char_valid),
    .char_ready_in       (char_ready),
    .overflow_out        (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance n cycles; outputs are sampled and inputs changed on the falling edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (!hold) imem_addr = imem_addr + 32'd4;
    end
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] we);
    dmem_addr = addr;
    dmem_data = data;
    dmem_we   = we;
    if (addr == CONSOLE && we[0] == 1'b1 && sb.size() < 4) sb.push_back(data[7:0]);
    tick(1);
    dmem_we   = 4'h0;
    dmem_addr = 32'h0000_1000;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    hold       = 1'b0;
    imem_addr  = 32'd0;
    dmem_addr  = 32'h0000_1000;
    dmem_data  = 32'd0;
    dmem_we    = 4'h0;
    char_ready = 1'b0;
    tick(2);
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic drain_check(input int n);
    for (int i = 0; i < n; i++) begin
      chk("drain_valid", {31'd0, char_valid}, 32'd1);
      exp_byte = (sb.size() > 0) ? sb.pop_front() : 8'h00;
      chk("drain_data", {24'd0, char_data}, {24'd0, exp_byte});
      tick(1);
    end
  endtask

  initial begin
    // Reset state
    rst = 1'b1; hold = 1'b0; imem_addr = 32'd0; dmem_addr = 32'h0000_1000;
    dmem_data = 32'd0; dmem_we = 4'h0; char_ready = 1'b0;
    tick(2);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_pass", {31'd0, pass}, 32'd0);
    chk("rst_status", {29'd0, status}, 32'(RUN));
    chk("rst_count", cycle_count, 32'd0);
    chk("rst_valid", {31'd0, char_valid}, 32'd0);
    chk("rst_data", {24'd0, char_data}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    chk("rst_fail", {1'b0, fail_code}, 32'd0);

    // PASS at cycle 20
    do_reset();
    tick(20);
    store(TOHOST, 32'd1, 4'hF);
    chk("pass_done", {31'd0, done}, 32'd1);
    chk("pass_pass", {31'd0, pass}, 32'd1);
    chk("pass_status", {29'd0, status}, 32'(PASS));
    chk("pass_count", cycle_count, 32'd21);
    tick(3);
    chk("pass_count_frozen", cycle_count, 32'd21);

    // FAIL, with ignored even and partial writes before it
    do_reset();
    tick(5);
    store(TOHOST, 32'd4, 4'hF);
    chk("even_ignored", {29'd0, status}, 32'(RUN));
    store(TOHOST, 32'h55, 4'h7);
    chk("partial_ignored", {29'd0, status}, 32'(RUN));
    store(TOHOST, 32'h57, 4'hF);
    chk("fail_status", {29'd0, status}, 32'(FAIL));
    chk("fail_code", {1'b0, fail_code}, 32'h2B);
    chk("fail_pass", {31'd0, pass}, 32'd0);
    chk("fail_done", {31'd0, done}, 32'd1);
    store(TOHOST, 32'd1, 4'hF);
    chk("fail_sticky", {29'd0, status}, 32'(FAIL));
    chk("fail_code_sticky", {1'b0, fail_code}, 32'h2B);

    // TIMEOUT at MAX_CYCLES=80
    do_reset();
    tick(79);
    chk("pre_timeout", {29'd0, status}, 32'(RUN));
    tick(1);
    chk("timeout_status", {29'd0, status}, 32'(TIMEOUT));
    chk("timeout_done", {31'd0, done}, 32'd1);
    chk("timeout_count", cycle_count, 32'd80);
    tick(2);
    chk("timeout_frozen", cycle_count, 32'd80);

    // tohost coincident with timeout wins
    do_reset();
    tick(79);
    store(TOHOST, 32'd1, 4'hF);
    chk("coinc_status", {29'd0, status}, 32'(PASS));
    chk("coinc_count", cycle_count, 32'd80);

    // HANG after 16 cycles at one PC
    do_reset();
    tick(10);
    hold = 1'b1; imem_addr = 32'h40;
    tick(15);
    chk("hang_pre", {29'd0, status}, 32'(RUN));
    tick(1);
    chk("hang_status", {29'd0, status}, 32'(HANG));
    chk("hang_done", {31'd0, done}, 32'd1);

    // 15 stalled cycles then a change: no HANG
    do_reset();
    tick(10);
    hold = 1'b1; imem_addr = 32'h40;
    tick(15);
    hold = 1'b0; imem_addr = 32'h100;
    tick(1);
    chk("nohang_a", {29'd0, status}, 32'(RUN));
    tick(5);
    chk("nohang_b", {29'd0, status}, 32'(RUN));

    // Console overflow on fifth byte, then drain a..d
    do_reset();
    for (int i = 0; i < 5; i++) store(CONSOLE, {24'd0, 8'h61 + 8'(i)}, 4'h1);
    chk("ovf_set", {31'd0, overflow}, 32'd1);
    chk("ovf_head", {24'd0, char_data}, 32'h61);
    tick(2);
    chk("head_stable", {24'd0, char_data}, 32'h61);
    char_ready = 1'b1;
    drain_check(4);
    chk("drained_valid", {31'd0, char_valid}, 32'd0);
    chk("drained_sb", sb.size(), 32'd0);
    char_ready = 1'b0;

    // Push and pop on a full FIFO: no overflow
    do_reset();
    for (int i = 0; i < 4; i++) store(CONSOLE, {24'd0, 8'h61 + 8'(i)}, 4'h1);
    char_ready = 1'b1;
    exp_byte = sb.pop_front();
    chk("full_pp_head", {24'd0, char_data}, {24'd0, exp_byte});
    store(CONSOLE, 32'h65, 4'h1);
    chk("full_pp_ovf", {31'd0, overflow}, 32'd0);
    drain_check(4);
    chk("full_pp_empty", {31'd0, char_valid}, 32'd0);
    char_ready = 1'b0;

    // Mid-test reset with buffered bytes
    do_reset();
    tick(48);
    store(CONSOLE, 32'h78, 4'h1);
    store(CONSOLE, 32'h79, 4'h1);
    chk("mid_count", cycle_count, 32'd50);
    chk("mid_valid", {31'd0, char_valid}, 32'd1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    sb.delete();
    chk("mid_rst_valid", {31'd0, char_valid}, 32'd0);
    chk("mid_rst_count", cycle_count, 32'd0);
    chk("mid_rst_status", {29'd0, status}, 32'(RUN));
    chk("mid_rst_ovf", {31'd0, overflow}, 32'd0);
    tick(1);
    chk("mid_rst_run", cycle_count, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
